// File: rtl/snake_game_master_fsm_if.sv
// Game-flow bus between the Snake master FSM and the surrounding button, score and display logic.
interface snake_game_master_fsm_if #(
    parameter int unsigned SCORE_WIDTH = 4,
    parameter int unsigned LIFE_WIDTH  = 2
);
    logic                   LEFT;
    logic                   RIGHT;
    logic                   UP;
    logic                   DOWN;
    logic                   PAUSE_BTN;
    logic                   COLLISION;
    logic [SCORE_WIDTH-1:0] SCORE_COUNT;
    logic [2:0]             STATE;
    logic [LIFE_WIDTH-1:0]  LIVES_LEFT;
    logic                   RESPAWN;
    logic                   GAME_OVER;

    modport master (
        input  LEFT, RIGHT, UP, DOWN, PAUSE_BTN, COLLISION, SCORE_COUNT,
        output STATE, LIVES_LEFT, RESPAWN, GAME_OVER
    );

    modport slave (
        output LEFT, RIGHT, UP, DOWN, PAUSE_BTN, COLLISION, SCORE_COUNT,
        input  STATE, LIVES_LEFT, RESPAWN, GAME_OVER
    );
endinterface

// File: rtl/snake_game_master_fsm.sv
// Snake game-flow controller: IDLE/PLAY/PAUSE/WIN/LOSE sequencing, lives tracking and timed end screen.
module snake_game_master_fsm #(
    parameter int unsigned SCORE_WIDTH = 4,
    parameter int unsigned WIN_SCORE   = 10,
    parameter int unsigned LIVES       = 3,
    parameter int unsigned LIFE_WIDTH  = 2,
    parameter int unsigned HOLD_CYCLES = 100_000_000,
    parameter int unsigned HOLD_WIDTH  = 27
) (
    input  logic                     CLK,
    input  logic                     RESETN,
    snake_game_master_fsm_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PLAY  = 3'd1,
        WIN   = 3'd2,
        LOSE  = 3'd3,
        PAUSE = 3'd4
    } state_t;

    localparam int unsigned NUM_BTN = 5;

    state_t                 state_q, state_d;
    logic [LIFE_WIDTH-1:0]  lives_q, lives_d;
    logic                   respawn_q, respawn_d;
    logic                   game_over_q, game_over_d;
    logic [HOLD_WIDTH-1:0]  hold_q, hold_d;
    logic [NUM_BTN-1:0]     btn_prev_q;
    logic [NUM_BTN-1:0]     btn_now;
    logic [NUM_BTN-1:0]     btn_rise;
    logic                   dir_edge;
    logic                   pause_edge;
    logic                   win_hit;

    // Bit order: {PAUSE_BTN, DOWN, UP, RIGHT, LEFT}
    assign btn_now    = {bus.PAUSE_BTN, bus.DOWN, bus.UP, bus.RIGHT, bus.LEFT};
    assign btn_rise   = btn_now & ~btn_prev_q;
    assign dir_edge   = |btn_rise[3:0];
    assign pause_edge = btn_rise[4];
    assign win_hit    = bus.SCORE_COUNT >= SCORE_WIDTH'(WIN_SCORE);

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q     <= IDLE;
            lives_q     <= LIFE_WIDTH'(LIVES);
            respawn_q   <= 1'b0;
            game_over_q <= 1'b0;
            hold_q      <= '0;
            btn_prev_q  <= '1;
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            respawn_q   <= respawn_d;
            game_over_q <= game_over_d;
            hold_q      <= hold_d;
            btn_prev_q  <= btn_now;
        end
    end

    always_comb begin
        state_d   = state_q;
        lives_d   = lives_q;
        respawn_d = 1'b0;
        hold_d    = hold_q;

        unique case (state_q)
            IDLE: begin
                if (dir_edge) begin
                    state_d = PLAY;
                    lives_d = LIFE_WIDTH'(LIVES);
                    hold_d  = '0;
                end
            end
            PLAY: begin
                // Win outranks collision; a collision swallows a same-cycle pause edge.
                if (win_hit) begin
                    state_d = WIN;
                end else if (bus.COLLISION) begin
                    if (lives_q > LIFE_WIDTH'(1)) begin
                        lives_d   = lives_q - LIFE_WIDTH'(1);
                        respawn_d = 1'b1;
                    end else begin
                        state_d = LOSE;
                        lives_d = '0;
                    end
                end else if (pause_edge) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (pause_edge) begin
                    state_d = PLAY;
                end
            end
            WIN, LOSE: begin
                if (hold_q == HOLD_WIDTH'(HOLD_CYCLES - 1)) begin
                    state_d = IDLE;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + HOLD_WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = '0;
            end
        endcase

        game_over_d = (state_d == WIN) || (state_d == LOSE);
    end

    assign bus.STATE      = state_q;
    assign bus.LIVES_LEFT = lives_q;
    assign bus.RESPAWN    = respawn_q;
    assign bus.GAME_OVER  = game_over_q;

endmodule
